llc_snoop_responder: RTL

Snoop-side controller for the last-level cache. It accepts bus operations issued by other caches and looks up the addressed line through the tag-array lookup port. It then computes the snoop result and the next MESI state, and issues any required L2→L1 messages (GETLINE / INVALIDATELINE) and a WRITE writeback on a HITM. It is the consumer of snooped bus traffic and the producer of the snoop result and L1-message streams reported at the bus-function layer.

---
 rtl/llc_snoop_responder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/llc_snoop_responder.sv
// Snoop-side controller for the last-level cache: looks up snooped lines, computes the
// snoop result and next MESI state, and issues L1 messages and HITM writebacks.
module llc_snoop_responder #(
    parameter int          ADDR_W     = 32,
    parameter logic [3:0]  CACHE_ID   = 4'h0,
    parameter int          LINE_OFF_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snp_valid,
    output logic              snp_ready,
    input  logic [2:0]        snp_op,
    input  logic [ADDR_W-1:0] snp_addr,
    input  logic [3:0]        snp_id,
    output logic              lkp_req,
    output logic [ADDR_W-1:0] lkp_addr,
    input  logic              lkp_valid,
    input  logic              lkp_hit,
    input  logic [1:0]        lkp_state,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [1:0]        upd_state,
    output logic              rsp_valid,
    output logic [1:0]        rsp_result,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              l1_valid,
    input  logic              l1_ready,
    output logic [2:0]        l1_msg,
    output logic [ADDR_W-1:0] l1_addr,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [2:0]        wb_op,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [31:0]       snoop_cnt,
    output logic [31:0]       hitm_cnt,
    output logic              err_proto,
    output logic              err_op
);

    localparam logic [2:0] OP_READ       = 3'd1;
    localparam logic [2:0] OP_WRITE      = 3'd2;
    localparam logic [2:0] OP_INVALIDATE = 3'd3;
    localparam logic [2:0] OP_RWIM       = 3'd4;

    localparam logic [2:0] MSG_GETLINE = 3'd1;
    localparam logic [2:0] MSG_INVLINE = 3'd3;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    localparam logic [1:0] RES_NOHIT = 2'd0;
    localparam logic [1:0] RES_HIT   = 2'd1;
    localparam logic [1:0] RES_HITM  = 2'd2;

    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_OFF_W;
    localparam logic [31:0]       CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, L1_GET, L1_INV, WB, RESP} state_e;

    state_e            state, state_next;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] line_addr;
    logic [1:0]        line_q;
    logic              lkp_first;
    logic              foreign, legal;

    logic [1:0] dec_result;
    logic [1:0] upd_new;
    logic       need_get, need_inv, need_wb, upd_due, proto_bad;

    assign line_addr = addr_q & LINE_MASK;
    assign foreign   = (snp_id != CACHE_ID);
    assign legal     = (snp_op >= OP_READ) && (snp_op <= OP_RWIM);
    assign snp_ready = (state == IDLE) && !rst;

    // Snoop decision from the captured op and the looked-up line state (a miss is held as I).
    always_comb begin
        dec_result = RES_NOHIT;
        need_get   = 1'b0;
        need_inv   = 1'b0;
        need_wb    = 1'b0;
        upd_due    = 1'b0;
        upd_new    = ST_I;
        proto_bad  = 1'b0;
        case (op_q)
            OP_READ: begin
                case (line_q)
                    ST_S: dec_result = RES_HIT;
                    ST_E: begin
                        dec_result = RES_HIT;
                        upd_due    = 1'b1;
                        upd_new    = ST_S;
                    end
                    ST_M: begin
                        dec_result = RES_HITM;
                        need_get   = 1'b1;
                        need_wb    = 1'b1;
                        upd_due    = 1'b1;
                        upd_new    = ST_S;
                    end
                    default: ;
                endcase
            end
            OP_RWIM: begin
                if (line_q != ST_I) begin
                    dec_result = (line_q == ST_M) ? RES_HITM : RES_HIT;
                    need_get   = (line_q == ST_M);
                    need_wb    = (line_q == ST_M);
                    need_inv   = 1'b1;
                    upd_due    = 1'b1;
                    upd_new    = ST_I;
                end
            end
            OP_INVALIDATE: begin
                if (line_q == ST_S) begin
                    dec_result = RES_HIT;
                    need_inv   = 1'b1;
                    upd_due    = 1'b1;
                    upd_new    = ST_I;
                end
                proto_bad = (line_q == ST_E) || (line_q == ST_M);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        lkp_req    = 1'b0;
        l1_valid   = 1'b0;
        l1_msg     = 3'd0;
        wb_valid   = 1'b0;
        rsp_valid  = 1'b0;
        upd_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (snp_valid && foreign && legal)
                    state_next = (snp_op == OP_WRITE) ? RESP : LOOKUP;
            end
            LOOKUP: begin
                lkp_req = lkp_first;
                if (lkp_valid && !lkp_first)
                    state_next = DECIDE;
            end
            DECIDE: begin
                if (need_get)      state_next = L1_GET;
                else if (need_inv) state_next = L1_INV;
                else if (need_wb)  state_next = WB;
                else               state_next = RESP;
            end
            L1_GET: begin
                l1_valid = 1'b1;
                l1_msg   = MSG_GETLINE;
                if (l1_ready) begin
                    if (need_inv)     state_next = L1_INV;
                    else if (need_wb) state_next = WB;
                    else              state_next = RESP;
                end
            end
            L1_INV: begin
                l1_valid = 1'b1;
                l1_msg   = MSG_INVLINE;
                if (l1_ready)
                    state_next = need_wb ? WB : RESP;
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready)
                    state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                upd_valid  = upd_due;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Payloads are forced to zero whenever their strobe is low.
    assign lkp_addr   = lkp_req   ? line_addr  : '0;
    assign l1_addr    = l1_valid  ? line_addr  : '0;
    assign wb_addr    = wb_valid  ? line_addr  : '0;
    assign wb_op      = wb_valid  ? OP_WRITE   : 3'd0;
    assign rsp_addr   = rsp_valid ? addr_q     : '0;
    assign rsp_result = rsp_valid ? dec_result : RES_NOHIT;
    assign upd_addr   = upd_valid ? line_addr  : '0;
    assign upd_state  = upd_valid ? upd_new    : ST_I;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 3'd0;
            addr_q    <= '0;
            line_q    <= ST_I;
            lkp_first <= 1'b0;
        end else begin
            state     <= state_next;
            lkp_first <= (state_next == LOOKUP) && (state != LOOKUP);
            if (state == IDLE && snp_valid) begin
                op_q   <= snp_op;
                addr_q <= snp_addr;
                line_q <= ST_I;
            end
            if (state == LOOKUP && !lkp_first && lkp_valid)
                line_q <= lkp_hit ? lkp_state : ST_I;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snoop_cnt <= 32'd0;
            hitm_cnt  <= 32'd0;
            err_proto <= 1'b0;
            err_op    <= 1'b0;
        end else begin
            if (state == IDLE && snp_valid && foreign) begin
                if (!legal)
                    err_op <= 1'b1;
                else if (snoop_cnt != CNT_MAX)
                    snoop_cnt <= snoop_cnt + 32'd1;
            end
            if (state == DECIDE && proto_bad)
                err_proto <= 1'b1;
            if (state == RESP && dec_result == RES_HITM && hitm_cnt != CNT_MAX)
                hitm_cnt <= hitm_cnt + 32'd1;
        end
    end

endmodule
